// File: rtl/mul_div_sequencer_if.sv
// Request/response bundle between the main controller and the HI/LO multiply/divide sequencer.
interface mul_div_sequencer_if #(parameter int WIDTH = 32);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] rs_val;
  logic [WIDTH-1:0] rt_val;
  logic             hilo_wr;
  logic             hilo_sel;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, rs_val, rt_val, hilo_wr, hilo_sel, wdata,
                  input  busy, done, hi, lo);
  modport slave  (input  start, op, rs_val, rt_val, hilo_wr, hilo_sel, wdata,
                  output busy, done, hi, lo);
endinterface

// File: rtl/mul_div_sequencer.sv
// Iterative radix-2 multiply / restoring-divide unit owning the HI/LO pair.
// Optional MD_FAST_MUL_EN: MULT/MULTU use a combinational product and skip CALC.
module mul_div_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  mul_div_sequencer_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]         r_state;
  logic [CW-1:0]      r_cnt;
  logic               r_is_div, r_neg_res, r_neg_rem, r_div0;
  logic [WIDTH-1:0]   r_m, r_hi, r_lo;
  logic [2*WIDTH-1:0] r_acc;

  logic               w_accept, w_rs_neg, w_rt_neg, w_fast;
  logic [WIDTH-1:0]   w_rs_abs, w_rt_abs;
  logic [2*WIDTH-1:0] w_acc_init, w_mul_nxt, w_div_nxt, w_prod;
  logic [WIDTH:0]     w_sum, w_shrem;
  logic [WIDTH-1:0]   w_diff, w_quo, w_rem;

  // DONE behaves like IDLE for acceptance so back-to-back ops lose no cycle.
  assign w_accept = bus.start & ((r_state == S_IDLE) | (r_state == S_DONE));
  assign w_rs_neg = ~bus.op[0] & bus.rs_val[WIDTH-1];
  assign w_rt_neg = ~bus.op[0] & bus.rt_val[WIDTH-1];
  assign w_rs_abs = w_rs_neg ? -bus.rs_val : bus.rs_val;
  assign w_rt_abs = w_rt_neg ? -bus.rt_val : bus.rt_val;

`ifdef MD_FAST_MUL_EN
  assign w_fast     = ~bus.op[1];
  assign w_acc_init = w_fast ? ({{WIDTH{1'b0}}, w_rs_abs} * {{WIDTH{1'b0}}, w_rt_abs})
                             : {{WIDTH{1'b0}}, w_rs_abs};
`else
  assign w_fast     = 1'b0;
  assign w_acc_init = {{WIDTH{1'b0}}, bus.op[1] ? w_rs_abs : w_rt_abs};
`endif

  // Multiply: low half holds the multiplier, product grows in from the top.
  assign w_sum     = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_m} : '0);
  assign w_mul_nxt = {w_sum, r_acc[WIDTH-1:1]};

  // Divide: upper half is the partial remainder, low half shifts dividend out / quotient in.
  assign w_shrem   = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_diff    = w_shrem[WIDTH-1:0] - r_m;
  assign w_div_nxt = (w_shrem >= {1'b0, r_m}) ? {w_diff, r_acc[WIDTH-2:0], 1'b1}
                                              : {r_acc[2*WIDTH-2:0], 1'b0};

  // A zero divisor leaves the remainder equal to |rs|, so only the quotient needs forcing.
  assign w_prod = r_neg_res ? -r_acc : r_acc;
  assign w_quo  = r_div0 ? '1 : (r_neg_res ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0]);
  assign w_rem  = r_neg_rem ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_is_div  <= 1'b0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_div0    <= 1'b0;
      r_m       <= '0;
      r_acc     <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
    end else begin
      case (r_state)
        S_CALC: begin
          r_acc <= r_is_div ? w_div_nxt : w_mul_nxt;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST) r_state <= S_FIX;
        end
        S_FIX: begin
          if (r_is_div) begin
            r_hi <= w_rem;
            r_lo <= w_quo;
          end else begin
            {r_hi, r_lo} <= w_prod;
          end
          r_state <= S_DONE;
        end
        default: begin
          if (w_accept) begin
            r_is_div  <= bus.op[1];
            r_neg_res <= w_rs_neg ^ w_rt_neg;
            r_neg_rem <= w_rs_neg;
            r_div0    <= bus.op[1] & (bus.rt_val == '0);
            r_m       <= bus.op[1] ? w_rt_abs : w_rs_abs;
            r_acc     <= w_acc_init;
            r_cnt     <= '0;
            r_state   <= w_fast ? S_FIX : S_CALC;
          end else begin
            if (bus.hilo_wr) begin
              if (bus.hilo_sel) r_hi <= bus.wdata;
              else              r_lo <= bus.wdata;
            end
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign bus.busy = (r_state == S_CALC) | (r_state == S_FIX);
  assign bus.done = (r_state == S_DONE);
  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;
endmodule
